pipelined_adder: RTL and testbench

//   Parametrised, pipelined WIDTH-bit adder. Successor to the single-bit half-adder cell.
//   - Splits operands into SEG-bit segments, one segment per pipeline stage; carry ripples stage-to-stage.
//   - valid/ready handshake on input and output; full throughput of 1 op/cycle; backpressure supported.
//   - Used wherever a wide add must close timing at clock rate.

---
 rtl/pipelined_adder_pkg.sv | 24 ++
 rtl/pipelined_adder_seg.sv | 38 +++
 rtl/pipelined_adder.sv | 145 ++++++++++++++
 tb/tb_pipelined_adder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_adder_pkg.sv
// -----------------------------------------------------------------------------
// pipelined_adder_pkg
//   Shared constants and helpers for the segmented pipelined adder.
//   - DEF_WIDTH / DEF_SEG : default operand width and bits added per stage
//   - calc_stages()       : number of pipeline stages (= latency)
//   - seg_fits()          : configuration check, WIDTH must be a positive
//                           multiple of SEG
//   The per-stage payload struct depends on WIDTH, so the top module declares
//   it locally from its own parameters.
// -----------------------------------------------------------------------------
package pipelined_adder_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_SEG   = 8;

   function automatic int calc_stages(input int width, input int seg);
      return width / seg;
   endfunction

   function automatic bit seg_fits(input int width, input int seg);
      return (seg > 0) && (width >= seg) && ((width % seg) == 0);
   endfunction

endpackage

// File: rtl/pipelined_adder_seg.sv
// -----------------------------------------------------------------------------
// adder_seg
//   Combinational W-bit ripple-carry adder built from half-adder pairs.
//   Ports:
//     a, b  in  W  operand segments
//     ci    in  1  carry in
//     s     out W  segment sum
//     co    out 1  carry out of the segment MSB
// -----------------------------------------------------------------------------
module adder_seg #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         ci,
   output logic [W-1:0] s,
   output logic         co
);

   logic [W:0] c;

   assign c[0] = ci;

   for (genvar i = 0; i < W; i++) begin : g_bit
      logic p, g_ab, g_pc;
      // first half adder: a + b
      assign p    = a[i] ^ b[i];
      assign g_ab = a[i] & b[i];
      // second half adder: partial sum + incoming carry
      assign s[i] = p ^ c[i];
      assign g_pc = p & c[i];
      // the two half-adder carries can never both be set
      assign c[i+1] = g_ab | g_pc;
   end

   assign co = c[W];

endmodule

// File: rtl/pipelined_adder.sv
// -----------------------------------------------------------------------------
// pipelined_adder
//   WIDTH-bit adder split into SEG-bit segments, one segment per stage, with
//   the carry rippling stage to stage. valid/ready on both sides, 1 op/cycle,
//   full backpressure. Latency STAGES = WIDTH/SEG cycles.
//   Optional feature macro: PIPELINED_ADDER_OVF_EN adds the signed overflow
//   output ovf (operand signs travel with the op to the last stage).
//   Ports:
//     clk, rst_n            clock, synchronous active-low reset
//     in_valid/in_ready     input handshake for a, b, cin
//     a, b [WIDTH]          operands
//     cin                   carry into bit 0
//     out_valid/out_ready   output handshake for sum, cout (, ovf)
//     sum [WIDTH]           (a+b+cin) mod 2^WIDTH
//     cout                  carry out of bit WIDTH-1
//     ovf                   signed overflow (PIPELINED_ADDER_OVF_EN only)
// -----------------------------------------------------------------------------
module pipelined_adder
   import pipelined_adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SEG   = DEF_SEG
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef PIPELINED_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int STAGES = calc_stages(WIDTH, SEG);
   localparam bit SEG_OK = seg_fits(WIDTH, SEG);

   if (!SEG_OK) begin : g_bad_cfg
      $error("pipelined_adder: WIDTH must be a positive multiple of SEG");
   end

   // Operand bits not yet added are kept shifted down so every stage adds
   // the low SEG bits; finished sum bits stay at their final position.
   typedef struct packed {
      logic [WIDTH-1:0] a_rem;
      logic [WIDTH-1:0] b_rem;
      logic [WIDTH-1:0] s;
      logic             c;
`ifdef PIPELINED_ADDER_OVF_EN
      logic             a_msb;
      logic             b_msb;
`endif
   } stage_t;

   logic [STAGES-1:0] vld_q;
   logic [STAGES:0]   vld_pipe;   // [0] = in_valid, [k+1] = stage k
   logic [STAGES:0]   rdy;
   stage_t            pl  [STAGES];
   stage_t            nxt [STAGES];

   assign vld_pipe = {vld_q, in_valid};

   // A stage may load when it is empty or its successor loads too, so
   // bubbles collapse and a full pipe still moves while the sink accepts.
   always_comb begin
      rdy         = '0;
      rdy[STAGES] = out_ready;
      for (int k = STAGES - 1; k >= 0; k--)
         rdy[k] = !vld_pipe[k+1] || rdy[k+1];
   end

   assign in_ready = rdy[0];

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      stage_t         src;
      stage_t         nxt_k;
      logic [SEG-1:0] seg_s;
      logic           seg_co;

      if (k == 0) begin : g_first
         always_comb begin
            src       = '0;
            src.a_rem = a;
            src.b_rem = b;
            src.c     = cin;
`ifdef PIPELINED_ADDER_OVF_EN
            src.a_msb = a[WIDTH-1];
            src.b_msb = b[WIDTH-1];
`endif
         end
      end else begin : g_next
         assign src = pl[k-1];
      end

      adder_seg #(.W(SEG)) u_seg (
         .a  (src.a_rem[SEG-1:0]),
         .b  (src.b_rem[SEG-1:0]),
         .ci (src.c),
         .s  (seg_s),
         .co (seg_co)
      );

      always_comb begin
         nxt_k                 = src;
         nxt_k.a_rem           = src.a_rem >> SEG;
         nxt_k.b_rem           = src.b_rem >> SEG;
         nxt_k.s[k*SEG +: SEG] = seg_s;
         nxt_k.c               = seg_co;
      end

      assign nxt[k] = nxt_k;
   end

   // Payload only loads with a valid op, so empty stages never disturb
   // the output register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int k = 0; k < STAGES; k++) pl[k] <= '0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (rdy[k]) begin
               vld_q[k] <= vld_pipe[k];
               if (vld_pipe[k]) pl[k] <= nxt[k];
            end
         end
      end
   end

   assign out_valid = vld_pipe[STAGES];
   assign sum       = pl[STAGES-1].s;
   assign cout      = pl[STAGES-1].c;

`ifdef PIPELINED_ADDER_OVF_EN
   assign ovf = (pl[STAGES-1].a_msb == pl[STAGES-1].b_msb) &&
                (pl[STAGES-1].s[WIDTH-1] != pl[STAGES-1].a_msb);
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
module tb_pipelined_adder;

   localparam int WIDTH  = 32;
   localparam int SEG    = 8;
   localparam int STAGES = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             out_ready = 1'b0;
   logic             cin = 1'b0;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             in_ready;
   logic             out_valid;
   logic             cout;
   logic [WIDTH-1:0] sum;
`ifdef PIPELINED_ADDER_OVF_EN
   logic             ovf;
`endif

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   bit stop_rnd = 0;

   typedef struct {
      logic [31:0] s;
      logic        c;
      logic        o;
      int          acc;
      bit          exact;
   } exp_t;

   exp_t q[$];

   pipelined_adder #(.WIDTH(WIDTH), .SEG(SEG)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
`ifdef PIPELINED_ADDER_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Offer one op; the expected result is queued when the handshake is seen.
   task automatic send(input logic [31:0] x, input logic [31:0] y, input logic c,
                       input logic [31:0] es, input logic ec, input logic eo, input bit exact);
      exp_t e;
      int   t;
      a = x; b = y; cin = c; in_valid = 1'b1; t = 0;
      forever begin
         @(negedge clk);
         if (in_ready) begin
            e.s = es; e.c = ec; e.o = eo; e.acc = cyc; e.exact = exact;
            q.push_back(e);
            @(posedge clk); #1;
            break;
         end
         t++;
         if (t >= 500) begin
            n_chk++; n_fail++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", t);
            @(posedge clk); #1;
            break;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (q.size() != 0 && t < 2000) begin
         @(posedge clk);
         t++;
      end
      #1;
      chk("drain_empty", 64'(q.size()), 64'd0);
   endtask

   // Scoreboard monitor
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL unexpected_output: got sum %0h with nothing expected", sum);
            end else begin
               e = q.pop_front();
               chk("sum", 64'(sum), 64'(e.s));
               chk("cout", 64'(cout), 64'(e.c));
`ifdef PIPELINED_ADDER_OVF_EN
               chk("ovf", 64'(ovf), 64'(e.o));
`endif
               if (e.exact) chk("latency", 64'(cyc - e.acc), 64'(STAGES));
               else         chk("latency_min", 64'((cyc - e.acc) >= STAGES), 64'd1);
            end
         end
      end
   end

   initial begin : stim
      logic [31:0] x, y;
      logic        c, o;
      logic [32:0] r;

      // reset state
      rst_n = 1'b0;
      tick(3);
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_sum", 64'(sum), 64'd0);
      chk("rst_cout", 64'(cout), 64'd0);
`ifdef PIPELINED_ADDER_OVF_EN
      chk("rst_ovf", 64'(ovf), 64'd0);
`endif
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      tick(1);

      // carry ripple through all segments
      send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1);
      drain();

      // back-to-back streaming
      send(32'd1, 32'd2, 1'b0, 32'd3, 1'b0, 1'b0, 1);
      send(32'd10, 32'd20, 1'b0, 32'd30, 1'b0, 1'b0, 1);
      send(32'hFFFF_0000, 32'h0001_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1);
      drain();

      // signed overflow corners
      send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1);
      send(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1);
      drain();

      // backpressure: 6 ops offered, only STAGES fit
      out_ready = 1'b0;
      fork
         begin
            send(32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 0);
            send(32'h0000_0002, 32'h0000_0003, 1'b0, 32'h0000_0005, 1'b0, 1'b0, 0);
            send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 0);
            send(32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 0);
            send(32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0, 1'b0, 0);
            send(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 0);
         end
      join_none
      repeat (8) @(negedge clk);
      chk("bp_accepted", 64'(q.size()), 64'd4);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_sum", 64'(sum), 64'h2);
      repeat (3) @(negedge clk);
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_sum", 64'(sum), 64'h2);
      chk("bp_hold_cout", 64'(cout), 64'd0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait fork;
      drain();

      // reset with ops in flight
      out_ready = 1'b0;
      send(32'h0000_0005, 32'h0000_0006, 1'b0, 32'h0000_000B, 1'b0, 1'b0, 0);
      send(32'h0000_0007, 32'h0000_0008, 1'b1, 32'h0000_0010, 1'b0, 1'b0, 0);
      send(32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 32'h0000_0001, 1'b1, 1'b0, 0);
      tick(1);
      chk("mf_pre_out_valid", 64'(out_valid), 64'd1);
      rst_n = 1'b0;
      q.delete();
      @(posedge clk);
      @(negedge clk);
      chk("mf_out_valid", 64'(out_valid), 64'd0);
      chk("mf_in_ready", 64'(in_ready), 64'd1);
      chk("mf_sum", 64'(sum), 64'd0);
      chk("mf_cout", 64'(cout), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      tick(10);
      chk("mf_no_stale", 64'(out_valid), 64'd0);

      // random traffic with random backpressure
      fork
         begin
            while (!stop_rnd) begin
               @(posedge clk); #1;
               if (!stop_rnd) out_ready = ($urandom_range(3) != 0);
            end
         end
      join_none
      for (int i = 0; i < 10000; i++) begin
         x = $urandom;
         y = $urandom;
         c = 1'($urandom_range(1));
         if (i % 16 == 0) x = 32'hFFFF_FFFF;
         if (i % 16 == 8) y = ~x;
         r = {1'b0, x} + {1'b0, y} + {32'd0, c};
         o = (x[31] == y[31]) && (r[31] != x[31]);
         if ($urandom_range(3) == 0) tick($urandom_range(2) + 1);
         send(x, y, c, r[31:0], r[32], o, 0);
      end
      stop_rnd = 1;
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait fork;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
